// File: rtl/nixie_pkg.sv
// rtl/nixie_pkg.sv - shared digit type, blank pattern and hex-to-segment table
//
// digit_t   : one display position {blank, dp, val}
// SEG_BLANK : all segments off (active-low)
// DIGIT_DARK: value every bank entry takes after reset
// hex_to_seg: active-low 7-segment pattern for a hex nibble, dp bit off
package nixie_pkg;

    typedef struct packed {
        logic       blank;
        logic       dp;
        logic [3:0] val;
    } digit_t;

    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam digit_t     DIGIT_DARK = 6'b10_0000;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] v);
        logic [7:0] s;
        case (v)
            4'h0: s = 8'hC0;
            4'h1: s = 8'hF9;
            4'h2: s = 8'hA4;
            4'h3: s = 8'hB0;
            4'h4: s = 8'h99;
            4'h5: s = 8'h92;
            4'h6: s = 8'h82;
            4'h7: s = 8'hF8;
            4'h8: s = 8'h80;
            4'h9: s = 8'h90;
            4'hA: s = 8'h88;
            4'hB: s = 8'h83;
            4'hC: s = 8'hC6;
            4'hD: s = 8'hA1;
            4'hE: s = 8'h86;
            default: s = 8'h8E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/nixie_seg_encode.sv
// rtl/nixie_seg_encode.sv - combinational digit_t to active-low segment pattern
//
// digit_i : digit entry to show
// seg_o   : {dp,g,f,e,d,c,b,a}, active-low; all off when the entry is blank
module nixie_seg_encode
    import nixie_pkg::*;
(
    input  digit_t     digit_i,
    output logic [7:0] seg_o
);

    logic [7:0] hex_seg;

    assign hex_seg = hex_to_seg(digit_i.val);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!digit_i.blank) begin
            seg_o = {~digit_i.dp, hex_seg[6:0]};
        end
    end

endmodule

// File: rtl/nixie_scan_ctrl.sv
// rtl/nixie_scan_ctrl.sv - 8-digit multiplexed 7-segment scan controller
//
// clk, rst_n        : system clock, asynchronous active-low reset
// en                : 1 = scan runs, 0 = scan frozen and display blanked
// wr_valid/wr_ready : host write handshake into the shadow bank
// wr_idx/wr_data    : digit position and hex value
// wr_dp/wr_blank    : decimal point on / digit dark
// num               : current digit index for the select decoder
// seg               : registered active-low segment pattern
// frame_done        : one-cycle pulse after num wraps 7->0
module nixie_scan_ctrl
    import nixie_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [2:0] wr_idx,
    input  logic [3:0] wr_data,
    input  logic       wr_dp,
    input  logic       wr_blank,
    output logic [2:0] num,
    output logic [7:0] seg,
    output logic       frame_done
);

    localparam int              PW         = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0]   BLANK_END  = PW'(BLANK_CYCLES);

    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    num_q, num_d;
    logic [7:0]    seg_q, seg_d;
    logic          frame_done_q;
    logic          rdy_q;
    digit_t        shadow_q  [8];
    digit_t        display_q [8];

    logic          terminal;
    logic          commit;
    logic          wr_fire;
    digit_t        next_digit;
    logic [7:0]    enc_seg;

    assign terminal = en && (presc_q == PRESC_LAST);
    assign commit   = terminal && (num_q == 3'd7);
    // The commit edge copies the shadow bank; a write landing on that same
    // edge would be ambiguous, so it is held off by one cycle.
    assign wr_ready = rdy_q && !commit;
    assign wr_fire  = wr_valid && wr_ready;

    always_comb begin
        presc_d = presc_q;
        num_d   = num_q;
        if (en) begin
            if (terminal) begin
                presc_d = '0;
                num_d   = num_q + 3'd1;
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end
    end

    // seg is registered, so encode the digit that will be current after the
    // edge, taking the commit on that same edge into account.
    assign next_digit = commit ? shadow_q[num_d] : display_q[num_d];

    nixie_seg_encode u_encode (
        .digit_i (next_digit),
        .seg_o   (enc_seg)
    );

    always_comb begin
        seg_d = enc_seg;
        if (!en || (presc_d < BLANK_END)) begin
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q      <= '0;
            num_q        <= '0;
            seg_q        <= SEG_BLANK;
            frame_done_q <= 1'b0;
            rdy_q        <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow_q[i]  <= DIGIT_DARK;
                display_q[i] <= DIGIT_DARK;
            end
        end else begin
            presc_q      <= presc_d;
            num_q        <= num_d;
            seg_q        <= seg_d;
            frame_done_q <= commit;
            rdy_q        <= 1'b1;
            if (commit) begin
                for (int i = 0; i < 8; i++) begin
                    display_q[i] <= shadow_q[i];
                end
            end
            if (wr_fire) begin
                shadow_q[wr_idx] <= digit_t'({wr_blank, wr_dp, wr_data});
            end
        end
    end

    assign num        = num_q;
    assign seg        = seg_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_nixie_scan_ctrl.sv
// tb/tb_nixie_scan_ctrl.sv - scoreboard bench for nixie_scan_ctrl
module tb_nixie_scan_ctrl;

    localparam int DIV   = 4;
    localparam int BLANK = 1;
    localparam int FRAME = 8 * DIV;

    logic       clk;
    logic       drv_rst_n, drv_en, drv_v, drv_dp, drv_blank;
    logic [2:0] drv_idx;
    logic [3:0] drv_data;
    logic       wr_ready, frame_done;
    logic [2:0] num;
    logic [7:0] seg;

    nixie_scan_ctrl #(.SCAN_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
        .clk        (clk),
        .rst_n      (drv_rst_n),
        .en         (drv_en),
        .wr_valid   (drv_v),
        .wr_ready   (wr_ready),
        .wr_idx     (drv_idx),
        .wr_data    (drv_data),
        .wr_dp      (drv_dp),
        .wr_blank   (drv_blank),
        .num        (num),
        .seg        (seg),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] num;
        logic [7:0] seg;
        logic       fd;
        logic       rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] HEX [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Reference model: position within the frame as one integer, two banks
    // of plain arrays.
    int   m_pos;
    bit   m_rdy, m_fd, m_acc;
    bit   m_sh_blank [8], m_sh_dp [8], m_ds_blank [8], m_ds_dp [8];
    int   m_sh_val [8], m_ds_val [8];
    logic [7:0] m_seg;

    task automatic model_reset();
        m_pos = 0; m_rdy = 0; m_fd = 0; m_acc = 0; m_seg = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            m_sh_blank[i] = 1; m_sh_dp[i] = 0; m_sh_val[i] = 0;
            m_ds_blank[i] = 1; m_ds_dp[i] = 0; m_ds_val[i] = 0;
        end
    endtask

    function automatic logic [7:0] model_seg(input bit en_now);
        int d;
        logic [7:0] s;
        d = m_pos / DIV;
        if (!en_now || (m_pos % DIV) < BLANK || m_ds_blank[d]) return 8'hFF;
        s = HEX[m_sh_val[0] * 0 + m_ds_val[d]];
        if (m_ds_dp[d]) s[7] = 1'b0;
        return s;
    endfunction

    // Apply one rising edge to the model using the inputs present at it.
    task automatic model_edge();
        bit commit, ready;
        if (!drv_rst_n) begin
            model_reset();
            return;
        end
        commit = drv_en && (m_pos == FRAME - 1);
        ready  = m_rdy && !commit;
        m_acc  = drv_v && ready;
        if (commit) begin
            for (int i = 0; i < 8; i++) begin
                m_ds_blank[i] = m_sh_blank[i];
                m_ds_dp[i]    = m_sh_dp[i];
                m_ds_val[i]   = m_sh_val[i];
            end
        end
        if (m_acc) begin
            m_sh_blank[drv_idx] = drv_blank;
            m_sh_dp[drv_idx]    = drv_dp;
            m_sh_val[drv_idx]   = int'(drv_data);
        end
        if (drv_en) m_pos = (m_pos + 1) % FRAME;
        m_fd  = commit;
        m_seg = model_seg(drv_en);
        m_rdy = 1;
    endtask

    task automatic step(input bit r, input bit e, input bit v, input int idx,
                        input int d, input bit dp, input bit bl);
        exp_t x;
        @(posedge clk);
        #1;
        model_edge();
        drv_rst_n = r; drv_en = e; drv_v = v;
        drv_idx = 3'(idx); drv_data = 4'(d); drv_dp = dp; drv_blank = bl;
        if (!r) model_reset();
        x.num = 3'(m_pos / DIV);
        x.seg = m_seg;
        x.fd  = m_fd;
        x.rdy = m_rdy && !(e && (m_pos == FRAME - 1));
        exp_q.push_back(x);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1, 1, 0, 0, 0, 0, 0);
    endtask

    task automatic run_to(input int p);
        for (int k = 0; k < 2 * FRAME && m_pos != p; k++) idle(1);
    endtask

    task automatic write_digit(input int idx, input int d, input bit dp, input bit bl);
        step(1, 1, 1, idx, d, dp, bl);
        step(1, 1, 1, idx, d, dp, bl);
        for (int k = 0; k < 4 && !m_acc; k++) step(1, 1, 1, idx, d, dp, bl);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%h required=%h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t x;
            x = exp_q.pop_front();
            chk("num", {5'd0, num}, {5'd0, x.num});
            chk("seg", seg, x.seg);
            chk("frame_done", {7'd0, frame_done}, {7'd0, x.fd});
            chk("wr_ready", {7'd0, wr_ready}, {7'd0, x.rdy});
        end
    end

    initial begin
        drv_rst_n = 0; drv_en = 0; drv_v = 0; drv_idx = 0;
        drv_data = 0; drv_dp = 0; drv_blank = 0;
        model_reset();

        // reset, release, one dark frame and a second frame
        repeat (3) step(0, 0, 0, 0, 0, 0, 0);
        idle(FRAME + 34);

        // mid-frame write shows only after the next commit
        run_to(9);
        write_digit(3, 8, 1, 0);
        idle(2 * FRAME);

        // write held across the commit cycle is stalled one cycle
        run_to(FRAME - 2);
        write_digit(0, 1, 0, 0);
        idle(2 * FRAME + 4);

        // freeze at num=5, prescaler=2
        run_to(5 * DIV + 1);
        repeat (20) step(1, 0, 0, 0, 0, 0, 0);
        idle(12);

        // randomized traffic
        repeat (400) begin
            int r;
            r = $urandom_range(0, 99);
            step(r != 0, r >= 12, $urandom_range(0, 2) != 0, $urandom_range(0, 7),
                 $urandom_range(0, 15), $urandom_range(0, 1) == 1, $urandom_range(0, 5) == 0);
        end
        idle(2);

        // load all digits, show them, then reset mid-operation
        for (int i = 0; i < 8; i++) write_digit(i, 15 - i, i[0], 0);
        idle(2 * FRAME);
        run_to(13);
        repeat (2) step(0, 1, 0, 0, 0, 0, 0);
        idle(2 * FRAME + 4);

        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
